dcache_wt_dm: RTL
=================

Name: dcache_wt_dm

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
- Sits between the processor data port (cacheable region below 0x08000000) and the DRAM controller.
- Fully replaces the fixed always-miss data cache stub.
- Returns read hits one cycle after request, flags misses, and accepts refill data when DRAM read data comes back. Adds byte-enable write-update, single-cycle flush, and saturating hit/miss statistics counters.

Parameters:
- INDEX_BITS, 8, log2 of line count (lines = 2^INDEX_BITS); legal range 2..12.
- ADDR_BITS, 27, number of significant byte-address bits of the cacheable region.
- CNT_WIDTH, 32, width of the hit/miss statistics counters.

Ports:
- clk  in  1  clock.
- rst_async  in  1  reset, asynchronous, active-high.
- req_oe  in  1  access request, already qualified to the cacheable region.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data.
- req_we  in  4  byte write enables; any bit set = write access.
- hit  out  1  read hit, cycle after request.
- miss  out  1  read miss pulse, cycle after request.
- rdata  out  32  hit data, valid while hit=1.
- fill_valid  in  1  DRAM read data valid for the outstanding miss.
- fill_rdata  in  32  DRAM read data.
- flush  in  1  invalidate all lines.
- pending  out  1  miss outstanding, awaiting fill.
- hit_cnt  out  CNT_WIDTH  saturating read-hit count.
- miss_cnt  out  CNT_WIDTH  saturating read-miss count.

Behaviour:
- Address split: index = req_addr[2 +: INDEX_BITS]; tag = req_addr[ADDR_BITS-1 : 2+INDEX_BITS].
- Storage:
  - Data array: synchronous-read RAM, 2^INDEX_BITS x 32.
  - Tag array: RAM, 2^INDEX_BITS x tag width.
  - Valid bits: flop vector, cleared asynchronously by rst_async.
- Reset values: hit=0, miss=0, rdata=0, pending=0, hit_cnt=0, miss_cnt=0, all valid=0, pending address=0, kill flag=0.
- Read (req_oe=1, req_we=0), issued in cycle N. In N+1, exactly one of the following:
  - Hit (valid[index] && tag match): hit=1, rdata = stored word.
  - Miss: miss=1 for one cycle; pending=1; latch the request tag/index as pending address; clear kill flag.
- Write (req_oe=1, req_we!=0):
  - Never asserts hit or miss; DRAM is always written externally.
  - If the line hits: merge the enabled bytes into the data array in cycle N+1; valid and tag unchanged.
  - If the line misses: no allocation.
  - If pending=1 and the write address equals the pending address: set the kill flag.
- Fill:
  - fill_valid=1 while pending=1 and kill=0: write fill_rdata and the pending tag to the pending index; set valid; pending=0.
  - If kill=1: discard the data and set pending=0.
  - fill_valid while pending=0 is ignored.
  - Fill data is not forwarded on rdata; the DRAM path supplies the processor.
- Simultaneous events:
  - A read miss issued while pending=1 replaces the pending address; the subsequent fill applies to the newest miss.
  - A fill and a write hit to the same index in the same cycle: the fill is applied first, then the write bytes merge on top only if the write tag equals the fill tag.
  - A read to an index being filled in the same cycle sees the pre-fill state.
- Flush:
  - Clears all valid bits in one cycle and sets kill if pending=1.
  - A request in the flush cycle is evaluated after invalidation: reads miss, writes do not update.
- Counters:
  - hit_cnt increments on each hit pulse; miss_cnt increments on each miss pulse.
  - Both saturate at all-ones and are not cleared by flush.
- Latency: hit/miss always exactly 1 cycle after req_oe; no back-pressure; no internal stall.

Test Plan:
- Cold read: after reset, read 0x00000040 -> N+1 miss=1, hit=0, pending=1, miss_cnt=1. Then fill_valid with fill_rdata=0x12345678 -> pending=0. Re-read 0x00000040 -> hit=1, rdata=0x12345678, hit_cnt=1.
- Conflict eviction, INDEX_BITS=8:
  - Fill 0x00000040=0xAAAA0001, then read 0x00000440 (same index, different tag) -> miss.
  - Fill with 0xBBBB0002; read 0x00000040 -> miss; read 0x00000440 -> hit, rdata=0xBBBB0002.
- Byte write-update: line 0x00000080 holds 0x11223344; write req_we=4'b0101, wdata=0xAABBCCDD -> next read hits with rdata=0x11BB33DD. A write to uncached 0x00000100 -> no hit/miss, later read misses.
- Kill on stale fill: read miss 0x00000200, then write 0x00000200 before fill_valid -> fill of 0xDEADBEEF is discarded. Next read of 0x00000200 misses.
- Flush and reset mid-operation:
  - Two cached lines plus a pending miss, then flush -> both lines miss on re-read; the pending fill is discarded.
  - Asserting rst_async while pending=1 -> pending=0, counters 0, a later fill_valid is ignored.
- Counter saturation: CNT_WIDTH=4, 20 hits -> hit_cnt holds at 4'hF.

Source files
------------

// File: rtl/dcache_wt_dm_if.sv
// Processor/DRAM-side signal bundle for the direct-mapped write-through cache.
// The master drives requests, fill returns and flush; the slave is the cache.
interface dcache_wt_dm_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 req_oe;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic [3:0]           req_we;
  logic                 hit;
  logic                 miss;
  logic [31:0]          rdata;
  logic                 fill_valid;
  logic [31:0]          fill_rdata;
  logic                 flush;
  logic                 pending;
  logic [CNT_WIDTH-1:0] hit_cnt;
  logic [CNT_WIDTH-1:0] miss_cnt;

  modport master (
    output req_oe, req_addr, req_wdata, req_we, fill_valid, fill_rdata, flush,
    input  hit, miss, rdata, pending, hit_cnt, miss_cnt
  );

  modport slave (
    input  req_oe, req_addr, req_wdata, req_we, fill_valid, fill_rdata, flush,
    output hit, miss, rdata, pending, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dcache_wt_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Reads answer hit/miss one cycle after the request; a miss leaves one refill
// outstanding. Write hits merge their enabled bytes one cycle after the request.
module dcache_wt_dm #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_BITS  = 27,
  parameter int CNT_WIDTH  = 32
) (
  input  logic          clk,
  input  logic          rst_async,
  dcache_wt_dm_if.slave bus
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - 2 - INDEX_BITS;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_W-1:0]      tag_t;

  // storage
  logic [31:0]      data_mem [LINES];
  tag_t             tag_mem  [LINES];
  logic [LINES-1:0] valid;

  // request decode
  idx_t req_idx;
  tag_t req_tag;
  logic req_is_wr, rd_req, wr_req;

  // outstanding miss
  logic pending_q, kill_q;
  idx_t pend_idx;
  tag_t pend_tag;

  // write merge stage (request cycle + 1)
  logic        s1_wr_hit;
  idx_t        s1_idx;
  tag_t        s1_tag;
  logic [3:0]  s1_be;
  logic [31:0] s1_wdata;
  logic [31:0] rd_word;

  logic        fill_apply, fill_at_s1, wr_commit;
  logic [31:0] commit_word, read_word, post_word;
  logic        line_hit, wr_hit;

  logic                 hit_q, miss_q;
  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[1:0], bus.req_addr[31:ADDR_BITS]};

  function automatic logic [31:0] merge(input logic [31:0] base,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

  // Hit evaluation, fill/merge collision resolution and forwarding.
  // Reads see the pre-fill line; writes see the post-fill line so a fill and
  // a write to the same index resolve as "fill first, then bytes on top".
  always_comb begin
    req_idx    = bus.req_addr[2 +: INDEX_BITS];
    req_tag    = bus.req_addr[ADDR_BITS-1 : 2+INDEX_BITS];
    req_is_wr  = |bus.req_we;
    rd_req     = bus.req_oe && !req_is_wr;
    wr_req     = bus.req_oe &&  req_is_wr;

    fill_apply = bus.fill_valid && pending_q && !kill_q && !bus.flush;
    fill_at_s1 = fill_apply && (pend_idx == s1_idx);
    // a fill that replaces the line with another tag drops the pending merge
    wr_commit  = s1_wr_hit && (!fill_at_s1 || (s1_tag == pend_tag));
    commit_word = merge(fill_at_s1 ? bus.fill_rdata : rd_word, s1_wdata, s1_be);

    line_hit   = !bus.flush && valid[req_idx] && (tag_mem[req_idx] == req_tag);
    wr_hit     = (fill_apply && (pend_idx == req_idx)) ? (req_tag == pend_tag)
                                                       : line_hit;

    // merge landing this edge is forwarded so back-to-back accesses see it
    read_word  = (wr_commit && (s1_idx == req_idx)) ? commit_word
                                                    : data_mem[req_idx];
    if (wr_commit && (s1_idx == req_idx))
      post_word = commit_word;
    else if (fill_apply && (pend_idx == req_idx))
      post_word = bus.fill_rdata;
    else
      post_word = data_mem[req_idx];
  end

  // Data array: fill first, merge second so a same-index merge wins.
  always_ff @(posedge clk) begin
    if (fill_apply) data_mem[pend_idx] <= bus.fill_rdata;
    if (wr_commit)  data_mem[s1_idx]   <= commit_word;
  end

  // Tag array written only by refills.
  always_ff @(posedge clk) begin
    if (fill_apply) tag_mem[pend_idx] <= pend_tag;
  end

  // Valid bits: flush clears everything and beats a same-cycle fill.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async)      valid <= '0;
    else if (bus.flush) valid <= '0;
    else if (fill_apply) valid[pend_idx] <= 1'b1;
  end

  // Registered read word and write-merge stage.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      rd_word   <= '0;
      s1_wr_hit <= 1'b0;
      s1_idx    <= '0;
      s1_tag    <= '0;
      s1_be     <= '0;
      s1_wdata  <= '0;
    end else begin
      if (bus.req_oe) rd_word <= req_is_wr ? post_word : read_word;
      s1_wr_hit <= wr_req && wr_hit;
      s1_idx    <= req_idx;
      s1_tag    <= req_tag;
      s1_be     <= bus.req_we;
      s1_wdata  <= bus.req_wdata;
    end
  end

  // Outstanding miss tracking; a new miss always replaces the old one.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      pending_q <= 1'b0;
      kill_q    <= 1'b0;
      pend_idx  <= '0;
      pend_tag  <= '0;
    end else if (rd_req && !line_hit) begin
      pending_q <= 1'b1;
      kill_q    <= 1'b0;
      pend_idx  <= req_idx;
      pend_tag  <= req_tag;
    end else begin
      if (bus.fill_valid && pending_q) pending_q <= 1'b0;
      if (pending_q && (bus.flush ||
          (wr_req && (req_idx == pend_idx) && (req_tag == pend_tag))))
        kill_q <= 1'b1;
    end
  end

  // Hit/miss pulses and saturating statistics.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_q  <= rd_req &&  line_hit;
      miss_q <= rd_req && !line_hit;
      if (rd_req &&  line_hit && (hit_cnt_q  != '1)) hit_cnt_q  <= hit_cnt_q  + 1'b1;
      if (rd_req && !line_hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign bus.hit      = hit_q;
  assign bus.miss     = miss_q;
  assign bus.rdata    = rd_word;
  assign bus.pending  = pending_q;
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;

endmodule
